// File: rtl/ldpc_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_phase_scheduler
//  Description : Top-level phase sequencer for the LDPC PE_BLOCK array.
//                Steps a codeword through intrinsic load, alternating CNU and
//                VNU sweeps separated by pipeline-flush gaps, and hard-decision
//                readout. Drives the shared address streams and the phase
//                enables broadcast to every PE_BLOCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldpc_phase_scheduler #(
  parameter int L          = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNU_DELAY  = 5,
  parameter int VNU_DELAY  = 3,
  parameter int ITER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  load_valid,
  input  logic                  parity_ok,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] load_add,
  output logic [ADDR_WIDTH-1:0] proc_add,
  output logic [ADDR_WIDTH-1:0] read_add,
  output logic                  read_valid,
  output logic                  rs,
  output logic                  enable_cnu,
  output logic                  enable_vnu,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  done,
  output logic                  converged
);

  // Flush counter only has to reach the longer of the two pipeline depths.
  localparam int c_DLY_MAX = (CNU_DELAY > VNU_DELAY) ? CNU_DELAY : VNU_DELAY;
  localparam int c_FW      = $clog2(c_DLY_MAX + 1);

  localparam logic [ADDR_WIDTH-1:0] c_LAST     = ADDR_WIDTH'(L - 1);
  localparam logic [c_FW-1:0]       c_CNU_END  = c_FW'(CNU_DELAY - 1);
  localparam logic [c_FW-1:0]       c_VNU_END  = c_FW'(VNU_DELAY - 1);
  localparam logic [ITER_WIDTH-1:0] c_ITER_MAX = '1;
  localparam logic [ITER_WIDTH-1:0] c_ITER_ONE = ITER_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_CNU       = 3'd2,
    S_CNU_FLUSH = 3'd3,
    S_VNU       = 3'd4,
    S_VNU_FLUSH = 3'd5,
    S_READ      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_load_add;
  logic [ADDR_WIDTH-1:0] r_proc_add;
  logic [ADDR_WIDTH-1:0] r_read_add;
  logic                  r_read_valid;
  logic                  r_rs;
  logic                  r_en_cnu;
  logic                  r_en_vnu;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_limit;
  logic                  r_done;
  logic                  r_conv;
  logic [c_FW-1:0]       r_flush;

  logic [ITER_WIDTH-1:0] w_iter_inc;
  logic [ITER_WIDTH-1:0] w_limit_in;
  logic                  w_stop;

  // Saturating iteration increment, zero-limit promotion and termination test.
  assign w_iter_inc = (r_iter == c_ITER_MAX) ? r_iter : r_iter + c_ITER_ONE;
  assign w_limit_in = (max_iter == '0) ? c_ITER_ONE : max_iter;
  assign w_stop     = parity_ok || (w_iter_inc == r_limit);

  // Every output is a register, so there is no input-to-output path.
  assign busy       = r_busy;
  assign load_add   = r_load_add;
  assign proc_add   = r_proc_add;
  assign read_add   = r_read_add;
  assign read_valid = r_read_valid;
  assign rs         = r_rs;
  assign enable_cnu = r_en_cnu;
  assign enable_vnu = r_en_vnu;
  assign iter_count = r_iter;
  assign done       = r_done;
  assign converged  = r_conv;

  // Phase sequencer: state, counters and registered outputs updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_load_add   <= '0;
      r_proc_add   <= '0;
      r_read_add   <= '0;
      r_read_valid <= 1'b0;
      r_rs         <= 1'b0;
      r_en_cnu     <= 1'b0;
      r_en_vnu     <= 1'b0;
      r_iter       <= '0;
      r_limit      <= '0;
      r_done       <= 1'b0;
      r_conv       <= 1'b0;
      r_flush      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_limit    <= w_limit_in;
            r_iter     <= '0;
            r_conv     <= 1'b0;
            r_busy     <= 1'b1;
            r_load_add <= '0;
            r_state    <= S_LOAD;
          end
        end

        // Address advances only on valid words; an absent word simply stalls.
        S_LOAD: begin
          if (load_valid) begin
            if (r_load_add == c_LAST) begin
              r_load_add <= '0;
              r_proc_add <= '0;
              r_en_cnu   <= 1'b1;
              r_state    <= S_CNU;
            end else begin
              r_load_add <= r_load_add + 1'b1;
            end
          end
        end

        S_CNU: begin
          if (r_proc_add == c_LAST) begin
            r_en_cnu   <= 1'b0;
            r_proc_add <= '0;
            r_flush    <= '0;
            r_state    <= S_CNU_FLUSH;
          end else begin
            r_proc_add <= r_proc_add + 1'b1;
          end
        end

        // Let the CNU pipeline drain before the VNU sweep reads its results.
        S_CNU_FLUSH: begin
          if (r_flush == c_CNU_END) begin
            r_en_vnu <= 1'b1;
            r_rs     <= 1'b1;
            r_state  <= S_VNU;
          end else begin
            r_flush <= r_flush + 1'b1;
          end
        end

        S_VNU: begin
          if (r_proc_add == c_LAST) begin
            r_en_vnu   <= 1'b0;
            r_proc_add <= '0;
            r_flush    <= '0;
            r_state    <= S_VNU_FLUSH;
          end else begin
            r_proc_add <= r_proc_add + 1'b1;
          end
        end

        // Syndrome is only meaningful once the VNU pipeline has fully drained,
        // so parity_ok is looked at on the last flush cycle alone.
        S_VNU_FLUSH: begin
          if (r_flush == c_VNU_END) begin
            r_iter <= w_iter_inc;
            r_rs   <= 1'b0;
            if (w_stop) begin
              r_conv       <= parity_ok;
              r_read_valid <= 1'b1;
              r_read_add   <= '0;
              r_state      <= S_READ;
            end else begin
              r_en_cnu <= 1'b1;
              r_state  <= S_CNU;
            end
          end else begin
            r_flush <= r_flush + 1'b1;
          end
        end

        S_READ: begin
          if (r_read_add == c_LAST) begin
            r_read_valid <= 1'b0;
            r_read_add   <= '0;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_read_add <= r_read_add + 1'b1;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldpc_phase_scheduler
//  Description : Self-checking bench for ldpc_phase_scheduler. A per-cycle
//                expected trace is built from the phase schedule (load length,
//                sweep lengths, flush gaps, termination rule) and replayed
//                against the design in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldpc_phase_scheduler;

  localparam int L  = 32;
  localparam int AW = 5;
  localparam int CD = 5;
  localparam int VD = 3;
  localparam int IW = 4;
  localparam int ITER_SAT = (1 << IW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] max_iter;
  logic          load_valid;
  logic          parity_ok;
  logic          busy;
  logic [AW-1:0] load_add;
  logic [AW-1:0] proc_add;
  logic [AW-1:0] read_add;
  logic          read_valid;
  logic          rs;
  logic          enable_cnu;
  logic          enable_vnu;
  logic [IW-1:0] iter_count;
  logic          done;
  logic          converged;

  ldpc_phase_scheduler #(
    .L(L), .ADDR_WIDTH(AW), .CNU_DELAY(CD), .VNU_DELAY(VD), .ITER_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter),
    .load_valid(load_valid), .parity_ok(parity_ok), .busy(busy),
    .load_add(load_add), .proc_add(proc_add), .read_add(read_add),
    .read_valid(read_valid), .rs(rs), .enable_cnu(enable_cnu),
    .enable_vnu(enable_vnu), .iter_count(iter_count), .done(done),
    .converged(converged)
  );

  always #5 clk = ~clk;

  // One cycle of the expected trace: inputs to drive and outputs to expect.
  typedef struct {
    logic          start;
    logic [IW-1:0] mi;
    logic          lv;
    logic          po;
    logic          busy, rv, rs, ec, ev, dn, cv, chk_la;
    logic [AW-1:0] la, pa, ra;
    logic [IW-1:0] it;
  } step_t;

  step_t         plan[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic [IW-1:0] m_iter   = '0;
  logic          m_conv   = 1'b0;
  int            exp_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic step_t idle_step();
    step_t s = '{default: '0};
    s.lv = 1'($urandom);
    s.po = 1'($urandom);
    s.mi = IW'($urandom);
    s.it = m_iter;
    s.cv = m_conv;
    return s;
  endfunction

  // While busy, start pulses and max_iter changes are noise the design must ignore.
  function automatic step_t busy_step();
    step_t s = idle_step();
    s.start = ($urandom_range(0, 3) == 0);
    s.busy  = 1'b1;
    return s;
  endfunction

  // Build the full expected trace of one decode.
  // mode: 0 = load_valid always high, 1 = toggling 0/1, 2 = random.
  // pit : iteration whose final flush cycle reports parity_ok (0 = never).
  task automatic build(input int mode, input int mi, input int pit);
    step_t s;
    int cnt, k, n, lim, load_len;
    bit fin;
    plan.delete();
    s = idle_step();
    s.start = 1'b1;
    s.mi    = IW'(mi);
    plan.push_back(s);
    m_iter = '0;
    m_conv = 1'b0;
    lim = (mi == 0) ? 1 : mi;
    cnt = 0;
    k = 0;
    while (cnt < L) begin
      s = busy_step();
      case (mode)
        0:       s.lv = 1'b1;
        1:       s.lv = (k % 2 == 1);
        default: s.lv = 1'($urandom);
      endcase
      s.chk_la = 1'b1;
      s.la     = AW'(cnt);
      if (s.lv) cnt++;
      plan.push_back(s);
      k++;
    end
    load_len = k;
    n = 0;
    fin = 1'b0;
    while (!fin) begin
      for (int i = 0; i < L; i++) begin
        s = busy_step(); s.ec = 1'b1; s.pa = AW'(i); plan.push_back(s);
      end
      for (int j = 0; j < CD; j++) begin
        s = busy_step(); plan.push_back(s);
      end
      for (int i = 0; i < L; i++) begin
        s = busy_step(); s.ev = 1'b1; s.rs = 1'b1; s.pa = AW'(i); plan.push_back(s);
      end
      for (int j = 0; j < VD; j++) begin
        s = busy_step(); s.rs = 1'b1;
        if (j == VD - 1) s.po = (n + 1 == pit);
        plan.push_back(s);
      end
      n++;
      m_iter = IW'((n < ITER_SAT) ? n : ITER_SAT);
      if (n == pit) begin
        m_conv = 1'b1;
        fin = 1'b1;
      end else if (n == lim) begin
        fin = 1'b1;
      end
    end
    for (int i = 0; i < L; i++) begin
      s = busy_step(); s.rv = 1'b1; s.ra = AW'(i); plan.push_back(s);
    end
    s = busy_step(); s.dn = 1'b1; plan.push_back(s);
    for (int i = 0; i < 3; i++) begin
      s = idle_step(); plan.push_back(s);
    end
    exp_done = 1 + load_len + n * (2 * L + CD + VD) + L;
  endtask

  // Replay the trace: check outputs #1 after each edge, then drive that cycle's inputs.
  task automatic run(input int limit, input bit chk_done);
    int seen = -1;
    for (int idx = 0; idx < plan.size() && idx < limit; idx++) begin
      step_t s = plan[idx];
      @(posedge clk);
      #1;
      if (done === 1'b1 && seen < 0) seen = idx;
      chk("busy", busy, s.busy);
      chk("enable_cnu", enable_cnu, s.ec);
      chk("enable_vnu", enable_vnu, s.ev);
      chk("en_exclusive", enable_cnu & enable_vnu, 1'b0);
      chk("rs", rs, s.rs);
      chk("read_valid", read_valid, s.rv);
      chk("done", done, s.dn);
      chk("iter_count", iter_count, s.it);
      chk("converged", converged, s.cv);
      if (s.chk_la) chk("load_add", load_add, s.la);
      if (s.ec || s.ev) chk("proc_add", proc_add, s.pa);
      if (s.rv) chk("read_add", read_add, s.ra);
      start      = s.start;
      max_iter   = s.mi;
      load_valid = s.lv;
      parity_ok  = s.po;
    end
    if (chk_done) chk("done_cycle", seen, exp_done);
  endtask

  task automatic check_zero();
    chk("rst_busy", busy, 1'b0);
    chk("rst_load_add", load_add, '0);
    chk("rst_proc_add", proc_add, '0);
    chk("rst_read_add", read_add, '0);
    chk("rst_read_valid", read_valid, 1'b0);
    chk("rst_rs", rs, 1'b0);
    chk("rst_enable_cnu", enable_cnu, 1'b0);
    chk("rst_enable_vnu", enable_vnu, 1'b0);
    chk("rst_iter_count", iter_count, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_converged", converged, 1'b0);
  endtask

  initial begin
    int mi, pit;
    rst_n = 1'b0;
    start = 1'b0;
    max_iter = '0;
    load_valid = 1'b0;
    parity_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Two full iterations without convergence: done at 209.
    build(0, 2, 0);
    run(1 << 30, 1'b1);
    // Early parity success after the first iteration: done at 137.
    build(0, 4, 1);
    run(1 << 30, 1'b1);
    // Toggling load_valid stretches LOAD to 64 cycles.
    build(1, 1, 0);
    run(1 << 30, 1'b1);
    // Zero limit behaves as one iteration.
    build(0, 0, 0);
    run(1 << 30, 1'b1);
    // Parity success exactly on the limit iteration.
    build(0, 2, 2);
    run(1 << 30, 1'b1);
    // Randomised loads, limits and convergence points.
    for (int r = 0; r < 3; r++) begin
      mi  = $urandom_range(0, 4);
      pit = $urandom_range(0, mi + 1);
      build(2, mi, pit);
      run(1 << 30, 1'b1);
    end
    // Full-scale limit: iteration count reaches its maximum value.
    build(0, ITER_SAT, 0);
    run(1 << 30, 1'b1);

    // Asynchronous reset in the middle of the first VNU sweep.
    build(0, 3, 0);
    run(1 + L + L + CD + 10, 1'b0);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_zero();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero();
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_iter = '0;
    m_conv = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_after_reset", busy, 1'b0);
    end
    build(2, 2, 1);
    run(1 << 30, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
